// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM between a CPU port (0) and a DMA port (1).
// Each port holds one pending request; the FSM issues one RAM transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rstrb,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wmask,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_busy,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rstrb,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_wmask,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rstrb,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wmask,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] req_addr  [2];
    logic              req_rstrb [2];
    logic [31:0]       req_wdata [2];
    logic [3:0]        req_wmask [2];

    logic              pend_valid_q [2], pend_valid_d [2];
    logic              pend_wr_q    [2], pend_wr_d    [2];
    logic [ADDR_W-1:0] pend_addr_q  [2], pend_addr_d  [2];
    logic [31:0]       pend_wdata_q [2], pend_wdata_d [2];
    logic [3:0]        pend_wmask_q [2], pend_wmask_d [2];
    logic [31:0]       rdata_q      [2], rdata_d      [2];
    logic              rvalid_q     [2], rvalid_d     [2];

    logic              winner_q, winner_d;
    logic              last_grant_q, last_grant_d;
    logic              win;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_wmask_q, ram_wmask_d;
    logic              ram_rstrb_q, ram_rstrb_d;

    assign req_addr[0]  = cpu_addr;
    assign req_addr[1]  = dma_addr;
    assign req_rstrb[0] = cpu_rstrb;
    assign req_rstrb[1] = dma_rstrb;
    assign req_wdata[0] = cpu_wdata;
    assign req_wdata[1] = dma_wdata;
    assign req_wmask[0] = cpu_wmask;
    assign req_wmask[1] = dma_wmask;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_wmask_d = pend_wmask_q;
        rdata_d      = rdata_q;
        rvalid_d     = '{default: 1'b0};
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_rstrb_d  = 1'b0;
        ram_wmask_d  = 4'b0000;
        win          = 1'b0;

        // A strobe is only accepted by an idle port; a nonzero mask makes it a write.
        for (int p = 0; p < 2; p++) begin
            if (!pend_valid_q[p] && (req_rstrb[p] || req_wmask[p] != 4'b0000)) begin
                pend_valid_d[p] = 1'b1;
                pend_wr_d[p]    = (req_wmask[p] != 4'b0000);
                pend_addr_d[p]  = req_addr[p];
                pend_wdata_d[p] = req_wdata[p];
                pend_wmask_d[p] = req_wmask[p];
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_valid_q[0] || pend_valid_q[1]) begin
                    win          = (pend_valid_q[0] && pend_valid_q[1]) ? ~last_grant_q
                                                                        : pend_valid_q[1];
                    winner_d     = win;
                    last_grant_d = win;
                    ram_addr_d   = pend_addr_q[win];
                    ram_wdata_d  = pend_wdata_q[win];
                    ram_rstrb_d  = ~pend_wr_q[win];
                    ram_wmask_d  = pend_wr_q[win] ? pend_wmask_q[win] : 4'b0000;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (pend_wr_q[winner_q]) begin
                    pend_valid_d[winner_q] = 1'b0;
                    state_d                = IDLE;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Only a single-cycle RAM read latency is supported.
                if (RD_LATENCY == 1) begin
                    rdata_d[winner_q]      = ram_rdata;
                    rvalid_d[winner_q]     = 1'b1;
                    pend_valid_d[winner_q] = 1'b0;
                    state_d                = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_rstrb_q  <= 1'b0;
            ram_wmask_q  <= 4'b0000;
            for (int p = 0; p < 2; p++) begin
                pend_valid_q[p] <= 1'b0;
                pend_wr_q[p]    <= 1'b0;
                pend_addr_q[p]  <= '0;
                pend_wdata_q[p] <= '0;
                pend_wmask_q[p] <= 4'b0000;
                rdata_q[p]      <= '0;
                rvalid_q[p]     <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_rstrb_q  <= ram_rstrb_d;
            ram_wmask_q  <= ram_wmask_d;
            pend_valid_q <= pend_valid_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_wmask_q <= pend_wmask_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign cpu_rdata  = rdata_q[0];
    assign cpu_rvalid = rvalid_q[0];
    assign cpu_busy   = pend_valid_q[0];
    assign dma_rdata  = rdata_q[1];
    assign dma_rvalid = rvalid_q[1];
    assign dma_busy   = pend_valid_q[1];
    assign ram_addr   = ram_addr_q;
    assign ram_rstrb  = ram_rstrb_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_wmask  = ram_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timeline reference model, attached RAM, directed
// scenarios with literal expectations, and a randomized run with occasional resets.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] cpu_addr = '0, dma_addr = '0;
   logic        cpu_rstrb = 1'b0, dma_rstrb = 1'b0;
   logic [31:0] cpu_wdata = '0, dma_wdata = '0;
   logic [3:0]  cpu_wmask = '0, dma_wmask = '0;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        cpu_rvalid, dma_rvalid, cpu_busy, dma_busy;
   logic [31:0] ram_addr, ram_wdata;
   logic        ram_rstrb;
   logic [3:0]  ram_wmask;
   logic [31:0] ram_rdata = '0;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .RD_LATENCY(1)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
      .dma_addr(dma_addr), .dma_rstrb(dma_rstrb), .dma_wdata(dma_wdata), .dma_wmask(dma_wmask),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy),
      .ram_addr(ram_addr), .ram_rstrb(ram_rstrb), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
      .ram_rdata(ram_rdata)
   );

   // RAM contents: untouched words hold a fixed function of their address.
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] mdl_mem [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (mask[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] env_read(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] mdl_read(input logic [31:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
   endfunction

   // The RAM attached to the DUT: one-cycle read latency, byte-masked writes.
   always @(posedge clk) begin
      if (ram_rstrb) ram_rdata <= env_read(ram_addr);
      if (ram_wmask != 4'b0000) env_mem[ram_addr] = merge(env_read(ram_addr), ram_wdata, ram_wmask);
   end

   // Reference model: one request slot per port, and a granted transaction described by the
   // cycle it issues in. A read completes two cycles after issue, a write one cycle after.
   logic        in_rd [2], in_req [2];
   logic [3:0]  in_mask [2];
   logic [31:0] in_addr [2], in_wdata [2];
   assign in_rd[0] = cpu_rstrb;   assign in_rd[1] = dma_rstrb;
   assign in_mask[0] = cpu_wmask; assign in_mask[1] = dma_wmask;
   assign in_addr[0] = cpu_addr;  assign in_addr[1] = dma_addr;
   assign in_wdata[0] = cpu_wdata; assign in_wdata[1] = dma_wdata;
   assign in_req[0] = cpu_rstrb || cpu_wmask != 4'b0000;
   assign in_req[1] = dma_rstrb || dma_wmask != 4'b0000;

   logic        m_pend [2], pre_pend [2], m_wr [2];
   logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
   logic [3:0]  m_wmask [2];
   logic [31:0] m_ram_addr, m_ram_wdata, m_xact_rdata;
   bit          m_active;
   int          cyc, m_grant_cyc, m_rv_cyc, m_win, m_rv_port, m_last;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cyc = 0; m_active = 0; m_last = 1; m_win = 0;
         m_grant_cyc = -10; m_rv_cyc = -10; m_rv_port = 0;
         m_ram_addr = '0; m_ram_wdata = '0; m_xact_rdata = '0;
         for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_wr[p] = 0; m_addr[p] = '0; m_wdata[p] = '0;
            m_wmask[p] = '0; m_rdata[p] = '0;
         end
      end else begin
         pre_pend = m_pend;
         cyc++;
         if (!m_active && (pre_pend[0] || pre_pend[1])) begin
            m_win = (pre_pend[0] && pre_pend[1]) ? 1 - m_last : (pre_pend[0] ? 0 : 1);
            m_last = m_win;
            m_active = 1;
            m_grant_cyc = cyc;
            m_ram_addr = m_addr[m_win];
            m_ram_wdata = m_wdata[m_win];
            if (!m_wr[m_win]) m_xact_rdata = mdl_read(m_addr[m_win]);
         end else if (m_active) begin
            if (m_wr[m_win] && cyc == m_grant_cyc + 1) begin
               mdl_mem[m_addr[m_win]] = merge(mdl_read(m_addr[m_win]), m_wdata[m_win], m_wmask[m_win]);
               m_pend[m_win] = 0;
               m_active = 0;
            end else if (!m_wr[m_win] && cyc == m_grant_cyc + 2) begin
               m_rdata[m_win] = m_xact_rdata;
               m_rv_cyc = cyc;
               m_rv_port = m_win;
               m_pend[m_win] = 0;
               m_active = 0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pre_pend[p] && in_req[p]) begin
               m_pend[p] = 1;
               m_wr[p] = (in_mask[p] != 4'b0000);
               m_addr[p] = in_addr[p];
               m_wdata[p] = in_wdata[p];
               m_wmask[p] = in_mask[p];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Every cycle out of reset, all DUT outputs are compared with the model.
   always @(posedge clk) begin
      #1;
      if (resetn === 1'b1) begin
         checkOutput("cpu_busy", cpu_busy, m_pend[0]);
         checkOutput("dma_busy", dma_busy, m_pend[1]);
         checkOutput("cpu_rvalid", cpu_rvalid, (m_rv_cyc == cyc && m_rv_port == 0));
         checkOutput("dma_rvalid", dma_rvalid, (m_rv_cyc == cyc && m_rv_port == 1));
         checkOutput("cpu_rdata", cpu_rdata, m_rdata[0]);
         checkOutput("dma_rdata", dma_rdata, m_rdata[1]);
         checkOutput("ram_rstrb", ram_rstrb, (m_active && !m_wr[m_win] && cyc == m_grant_cyc));
         checkOutput("ram_wmask", ram_wmask,
                     (m_active && m_wr[m_win] && cyc == m_grant_cyc) ? m_wmask[m_win] : 4'b0000);
         checkOutput("ram_addr", ram_addr, m_ram_addr);
         checkOutput("ram_wdata", ram_wdata, m_ram_wdata);
      end
   end

   task automatic applyStimulus(input int port, input logic rd, input logic [3:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         cpu_rstrb = rd; cpu_wmask = mask; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         dma_rstrb = rd; dma_wmask = mask; dma_addr = addr; dma_wdata = wdata;
      end
   endtask

   task automatic clear_inputs();
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 4'b0000, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      resetn = 1'b0;
      #1;
      checkOutput("rst_busy", {cpu_busy, dma_busy}, 2'b00);
      checkOutput("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
      checkOutput("rst_ram_ctl", {ram_rstrb, ram_wmask}, 5'b0);
      checkOutput("rst_ram_addr_wdata", {ram_addr, ram_wdata}, 64'h0);
      checkOutput("rst_rdata", {cpu_rdata, dma_rdata}, 64'h0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   int grants [$];
   int fair_cycles;

   initial begin
      env_mem[32'h800] = 32'h0000_0013;
      mdl_mem[32'h800] = 32'h0000_0013;

      // Lone CPU read: strobe at N, RAM strobe at N+2, data back at N+4.
      do_reset();
      @(negedge clk); applyStimulus(0, 1'b1, 4'b0000, 32'h800, 32'h0);
      step();
      checkOutput("read_busy_n1", cpu_busy, 1'b1);
      @(negedge clk); clear_inputs();
      step();
      checkOutput("read_ram_rstrb_n2", ram_rstrb, 1'b1);
      checkOutput("read_ram_addr_n2", ram_addr, 32'h800);
      step(); step();
      checkOutput("read_rvalid_n4", cpu_rvalid, 1'b1);
      checkOutput("read_rdata_n4", cpu_rdata, 32'h0000_0013);
      checkOutput("read_busy_n4", cpu_busy, 1'b0);

      // Simultaneous CPU read and DMA write straight after reset: CPU first.
      do_reset();
      @(negedge clk);
      applyStimulus(0, 1'b1, 4'b0000, 32'h10, 32'h0);
      applyStimulus(1, 1'b0, 4'b1111, 32'h20, 32'hDEAD_BEEF);
      step();
      @(negedge clk); clear_inputs();
      step();
      checkOutput("tie_cpu_rstrb_n2", {ram_rstrb, ram_wmask}, 5'b1_0000);
      checkOutput("tie_cpu_addr_n2", ram_addr, 32'h10);
      step(); step(); step();
      checkOutput("tie_dma_wmask_n5", {ram_rstrb, ram_wmask}, 5'b0_1111);
      checkOutput("tie_dma_addr_n5", ram_addr, 32'h20);
      checkOutput("tie_dma_wdata_n5", ram_wdata, 32'hDEAD_BEEF);
      step();
      checkOutput("tie_dma_wmask_n6", ram_wmask, 4'b0000);
      checkOutput("tie_dma_busy_n6", dma_busy, 1'b0);

      // Strobe with mask is a write; the following strobe while busy is dropped.
      do_reset();
      @(negedge clk); applyStimulus(1, 1'b1, 4'b0100, 32'h40, 32'h00C0_0000);
      step();
      @(negedge clk); applyStimulus(1, 1'b1, 4'b0000, 32'h44, 32'h0);
      step();
      checkOutput("misuse_wmask_n2", {ram_rstrb, ram_wmask}, 5'b0_0100);
      @(negedge clk); clear_inputs();
      step();
      checkOutput("misuse_busy_n3", dma_busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("misuse_no_read", {ram_rstrb, dma_rvalid}, 2'b00);
      end

      // Byte write of a single lane.
      do_reset();
      @(negedge clk); applyStimulus(0, 1'b0, 4'b0010, 32'h80, 32'h0000_AB00);
      step();
      @(negedge clk); clear_inputs();
      step();
      checkOutput("bytewr_wmask_n2", ram_wmask, 4'b0010);
      checkOutput("bytewr_wdata_n2", ram_wdata, 32'h0000_AB00);
      step();
      checkOutput("bytewr_busy_n3", cpu_busy, 1'b0);

      // Reset during WAIT_RD aborts the read; a later read still completes.
      do_reset();
      @(negedge clk); applyStimulus(0, 1'b1, 4'b0000, 32'h900, 32'h0);
      @(negedge clk); clear_inputs();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("midrd_outputs", {cpu_busy, cpu_rvalid, ram_rstrb, ram_wmask}, 7'b0);
      checkOutput("midrd_ram_addr", ram_addr, 32'h0);
      @(negedge clk); resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checkOutput("midrd_no_rvalid", {cpu_rvalid, cpu_busy}, 2'b00);
      end
      @(negedge clk); applyStimulus(0, 1'b1, 4'b0000, 32'h800, 32'h0);
      @(negedge clk); clear_inputs();
      step(); step(); step();
      checkOutput("midrd_new_rvalid", cpu_rvalid, 1'b1);
      checkOutput("midrd_new_rdata", cpu_rdata, 32'h0000_0013);

      // Both ports re-request as soon as they are free: grants must alternate from port 0.
      do_reset();
      fair_cycles = 0;
      while (grants.size() < 8 && fair_cycles < 300) begin
         @(negedge clk);
         if (!cpu_busy)
            applyStimulus(0, 1'b1, ($urandom_range(0, 1) != 0) ? 4'b1111 : 4'b0000,
                          $urandom & 32'h0000_0FFC, $urandom);
         else
            applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
         if (!dma_busy)
            applyStimulus(1, 1'b1, ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b0000,
                          32'h0000_1000 | ($urandom & 32'h0000_0FFC), $urandom);
         else
            applyStimulus(1, 1'b0, 4'b0000, 32'h0, 32'h0);
         step();
         if (ram_rstrb || ram_wmask != 4'b0000) grants.push_back(int'(ram_addr[12]));
         fair_cycles++;
      end
      checkOutput("fair_grant_count", grants.size(), 8);
      foreach (grants[i]) checkOutput("fair_grant_order", grants[i], i % 2);

      // Randomized traffic, including strobes while busy and occasional resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            clear_inputs();
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
         end else begin
            for (int p = 0; p < 2; p++) begin
               if ($urandom_range(0, 2) == 0)
                  applyStimulus(p, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000,
                                ($urandom & 32'h0000_003C) | (p == 1 ? 32'h40 : 32'h0), $urandom);
               else
                  applyStimulus(p, 1'b0, 4'b0000, $urandom, $urandom);
            end
         end
      end
      @(negedge clk); clear_inputs();
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
